mem_access_stage: RTL and testbench

- Memory-access (MA) pipeline stage of the RV32I core. Consumes the EX/MA register outputs: control word, address, store data, byte enables and address offset.
- Issues the request to the data cache and holds the pipeline through a miss by driving MA_stall.
- Aligns and extends load data.
- Registers the result into MA/WB. The registered control word and data are also the forwarding path back to EX.

---
 rtl/rv32i_types.sv | 42 ++++
 rtl/mem_access_stage_load_align.sv | 25 ++
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types for the pipeline and the memory-access stage
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic {
        MA_IDLE   = 1'b0,
        MA_ACCESS = 1'b1
    } ma_state_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic        load_regfile;
        logic [4:0]  rd;
    } rv32i_control_word;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - shifts cache read data by the byte offset and extends it
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] mdr
);

    logic [31:0] shifted;

    // Bring the addressed byte/halfword down to bit 0, then extend per funct3.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            lb:      mdr = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     mdr = {24'b0, shifted[7:0]};
            lh:      mdr = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     mdr = {16'b0, shifted[15:0]};
            default: mdr = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MA stage: data-cache request, miss stall, load alignment, MA/WB register
module mem_access_stage
    import rv32i_types::*;
#(
    parameter int STALL_CNT_W = 32
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  rv32i_control_word      ctrl_word_in,
    input  logic [31:0]            instruction_in,
    input  logic [31:0]            PC_in,
    input  logic [31:0]            alu_in,
    input  logic [31:0]            rs2_in,
    input  logic [3:0]             mem_byte_enable_in,
    input  logic [1:0]             addr_offset_in,
    input  logic                   br_en_in,
    input  logic [31:0]            dmem_rdata,
    input  logic                   dmem_resp,
    output logic [31:0]            dmem_address,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_byte_enable,
    output logic                   MA_stall,
    output rv32i_control_word      ctrl_word_out,
    output logic [31:0]            instruction_out,
    output logic [31:0]            PC_out,
    output logic [31:0]            alu_out,
    output logic [31:0]            mdr_out,
    output logic [31:0]            wb_data_out,
    output logic                   br_en_out,
    output logic                   misalign_out,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    ma_state_t               state_q, state_d;
    rv32i_control_word       ctrl_q, ctrl_d;
    logic [31:0]             instr_q, instr_d;
    logic [31:0]             pc_q, pc_d;
    logic [31:0]             alu_q, alu_d;
    logic [31:0]             mdr_q, mdr_d;
    logic                    br_en_q, br_en_d;
    logic                    misalign_q, misalign_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [2:0]  funct3_in;
    logic        is_load, is_store, misaligned, issue;
    logic        req, stall_raw;
    logic [31:0] aligned;

    assign funct3_in = instruction_in[14:12];
    assign is_load   = (ctrl_word_in.opcode == op_load);
    assign is_store  = (ctrl_word_in.opcode == op_store);

    // Word accesses need offset 0; halfwords may not straddle the word boundary.
    always_comb begin
        misaligned = 1'b0;
        if (is_load)
            misaligned = ((funct3_in == lw) && (addr_offset_in != 2'd0)) ||
                         (((funct3_in == lh) || (funct3_in == lhu)) && (addr_offset_in == 2'd3));
        else if (is_store)
            misaligned = ((funct3_in == sw) && (addr_offset_in != 2'd0)) ||
                         ((funct3_in == sh) && (addr_offset_in == 2'd3));
    end

    assign issue = (is_load || is_store) && !misaligned;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (addr_offset_in),
        .funct3 (funct3_in),
        .mdr    (aligned)
    );

    // Request/stall FSM: a hit answered in the issue cycle never leaves IDLE.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        stall_raw = 1'b0;
        case (state_q)
            MA_IDLE: begin
                req       = issue;
                stall_raw = issue && !dmem_resp;
                if (issue && !dmem_resp)
                    state_d = MA_ACCESS;
            end
            MA_ACCESS: begin
                req       = 1'b1;
                stall_raw = !dmem_resp;
                if (dmem_resp)
                    state_d = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

    assign dmem_read        = req && is_load && !rst;
    assign dmem_write       = req && is_store && !rst;
    assign MA_stall         = stall_raw && !rst;
    assign dmem_address     = {alu_in[31:2], 2'b00};
    assign dmem_wdata       = rs2_in << {addr_offset_in, 3'b000};
    assign dmem_byte_enable = is_load ? 4'b1111 : mem_byte_enable_in;

    // MA/WB next values: capture whenever the stage is not stalled, otherwise hold.
    always_comb begin
        ctrl_d      = ctrl_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        br_en_d     = br_en_q;
        misalign_d  = misalign_q;
        stall_cnt_d = stall_cnt_q;
        if (MA_stall) begin
            if (stall_cnt_q != {STALL_CNT_W{1'b1}})
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
            ctrl_d       = ctrl_word_in;
            instr_d      = instruction_in;
            pc_d         = PC_in;
            alu_d        = alu_in;
            br_en_d      = br_en_in;
            misalign_d   = misaligned;
            mdr_d        = (is_load && !misaligned) ? aligned : 32'b0;
            if (misaligned)
                ctrl_d.load_regfile = 1'b0;
        end
    end

    // State and MA/WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MA_IDLE;
            ctrl_q      <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            br_en_q     <= 1'b0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            br_en_q     <= br_en_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forwarding value: load data, slt/sltu compare bit, or the ALU result.
    always_comb begin
        wb_data_out = alu_q;
        if (ctrl_q.opcode == op_load)
            wb_data_out = mdr_q;
        else if (((ctrl_q.opcode == op_reg) || (ctrl_q.opcode == op_imm)) &&
                 ((instr_q[14:12] == 3'b010) || (instr_q[14:12] == 3'b011)))
            wb_data_out = {31'b0, br_en_q};
    end

    assign ctrl_word_out   = ctrl_q;
    assign instruction_out = instr_q;
    assign PC_out          = pc_q;
    assign alu_out         = alu_q;
    assign mdr_out         = mdr_q;
    assign br_en_out       = br_en_q;
    assign misalign_out    = misalign_q;
    assign stall_cycles    = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
    import rv32i_types::*;

    localparam int SW_W = 2;

    logic              clk, rst;
    rv32i_control_word ctrl_word_in, ctrl_word_out;
    logic [31:0] instruction_in, PC_in, alu_in, rs2_in, dmem_rdata;
    logic [3:0]  mem_byte_enable_in, dmem_byte_enable;
    logic [1:0]  addr_offset_in;
    logic        br_en_in, dmem_resp;
    logic [31:0] dmem_address, dmem_wdata, instruction_out, PC_out, alu_out, mdr_out, wb_data_out;
    logic        dmem_read, dmem_write, MA_stall, br_en_out, misalign_out;
    logic [SW_W-1:0] stall_cycles;

    mem_access_stage #(.STALL_CNT_W(SW_W)) dut (
        .clk(clk), .rst(rst), .ctrl_word_in(ctrl_word_in), .instruction_in(instruction_in),
        .PC_in(PC_in), .alu_in(alu_in), .rs2_in(rs2_in), .mem_byte_enable_in(mem_byte_enable_in),
        .addr_offset_in(addr_offset_in), .br_en_in(br_en_in), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_address(dmem_address), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .MA_stall(MA_stall), .ctrl_word_out(ctrl_word_out), .instruction_out(instruction_out),
        .PC_out(PC_out), .alu_out(alu_out), .mdr_out(mdr_out), .wb_data_out(wb_data_out),
        .br_en_out(br_en_out), .misalign_out(misalign_out), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc, alu, mdr, wb;
        logic        mis, lrf, br;
        logic [1:0]  stall;
        int          hs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0, bad = 0;
    int   exp_hs = 0, hs_cnt = 0, exp_stall = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic mon_cap, mon_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rv32i_control_word mk_cw(input rv32i_opcode op, input logic lrf);
        rv32i_control_word c;
        c.opcode = op;
        c.load_regfile = lrf;
        c.rd = 5'd1;
        return c;
    endfunction

    // Monitor: every MA/WB capture edge pops one expectation.
    always @(posedge clk) begin
        mon_cap = !rst && !MA_stall;
        mon_hs  = !rst && (dmem_read || dmem_write) && dmem_resp;
        #1;
        if (mon_hs) hs_cnt++;
        if (mon_cap && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("instr_out", instruction_out, mon_e.instr);
            chk("pc_out", PC_out, mon_e.pc);
            chk("alu_out", alu_out, mon_e.alu);
            chk("mdr_out", mdr_out, mon_e.mdr);
            chk("wb_data_out", wb_data_out, mon_e.wb);
            chk("misalign_out", {31'b0, misalign_out}, {31'b0, mon_e.mis});
            chk("load_regfile", {31'b0, ctrl_word_out.load_regfile}, {31'b0, mon_e.lrf});
            chk("br_en_out", {31'b0, br_en_out}, {31'b0, mon_e.br});
            chk("stall_cycles", {30'b0, stall_cycles}, {30'b0, mon_e.stall});
            chk("handshakes", hs_cnt, mon_e.hs);
        end
    end

    // Present one instruction, answer with dmem_resp d cycles later, wait for capture.
    task automatic run_op(input rv32i_control_word cw, input logic [31:0] instr, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [3:0] be, input logic br, input int d,
                          input logic [31:0] rdata, input logic mis, input logic [31:0] e_mdr,
                          input logic e_lrf, input logic [31:0] e_wb, input logic [31:0] e_wdata,
                          input logic [3:0] e_be);
        exp_t e;
        logic is_ld, ereq, captured;
        @(negedge clk);
        ctrl_word_in = cw; instruction_in = instr; PC_in = pc_ctr; alu_in = alu;
        rs2_in = rs2; mem_byte_enable_in = be; addr_offset_in = alu[1:0]; br_en_in = br;
        dmem_rdata = rdata; dmem_resp = 1'b0;
        is_ld = (cw.opcode == op_load);
        ereq  = ((cw.opcode == op_load) || (cw.opcode == op_store)) && !mis;
        if (ereq) begin
            exp_hs++;
            exp_stall = (exp_stall + d > 3) ? 3 : exp_stall + d;
        end
        e.instr = instr; e.pc = pc_ctr; e.alu = alu; e.mdr = e_mdr; e.wb = e_wb;
        e.mis = mis; e.lrf = e_lrf; e.br = br; e.stall = 2'(exp_stall); e.hs = exp_hs;
        exp_q.push_back(e);
        pc_ctr = pc_ctr + 4;
        captured = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            dmem_resp = ereq && (k == d);
            #1;
            chk("dmem_read", {31'b0, dmem_read}, {31'b0, ereq && is_ld});
            chk("dmem_write", {31'b0, dmem_write}, {31'b0, ereq && !is_ld});
            chk("ma_stall", {31'b0, MA_stall}, {31'b0, ereq && (k < d)});
            if (k == 0 && ereq) begin
                chk("dmem_address", dmem_address, {alu[31:2], 2'b00});
                chk("dmem_wdata", dmem_wdata, e_wdata);
                chk("dmem_byte_enable", {28'b0, dmem_byte_enable}, {28'b0, e_be});
            end
            captured = !MA_stall;
            @(posedge clk);
            if (captured) break;
        end
        chk("capture", {31'b0, captured}, 32'd1);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        ctrl_word_in = mk_cw(op_load, 1'b1); instruction_in = 32'h0000_2003; PC_in = 32'h0;
        alu_in = 32'h100; rs2_in = 32'h0; mem_byte_enable_in = 4'hF; addr_offset_in = 2'd0; br_en_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_read_gated", {31'b0, dmem_read}, 32'd0);
        chk("rst_stall_gated", {31'b0, MA_stall}, 32'd0);
        chk("rst_ctrl", {19'b0, ctrl_word_out}, 32'd0);
        chk("rst_mdr", mdr_out, 32'd0);
        chk("rst_stall_cycles", {30'b0, stall_cycles}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_out}, 32'd0);
        rst = 1'b0; ctrl_word_in = '0; instruction_in = 32'h0; alu_in = 32'h0;

        // ctrl, instr, alu, rs2, be, br, d, rdata, mis, mdr, lrf, wb, wdata, be_out
        run_op(mk_cw(op_load, 1), 32'h0000_2003, 32'h100, 32'h0, 4'b0001, 0, 2, 32'h1122_3344, 0,
               32'h1122_3344, 1, 32'h1122_3344, 32'h0, 4'b1111);
        run_op(mk_cw(op_store, 0), 32'h0000_0023, 32'h203, 32'hAB, 4'b1000, 0, 0, 32'h0, 0,
               32'h0, 0, 32'h203, 32'hAB00_0000, 4'b1000);
        run_op(mk_cw(op_load, 1), 32'h0000_0003, 32'h302, 32'h0, 4'b0100, 0, 1, 32'h12F4_5678, 0,
               32'hFFFF_FFF4, 1, 32'hFFFF_FFF4, 32'h0, 4'b1111);
        run_op(mk_cw(op_load, 1), 32'h0000_4003, 32'h302, 32'h0, 4'b0100, 0, 2, 32'h12F4_5678, 0,
               32'h0000_00F4, 1, 32'h0000_00F4, 32'h0, 4'b1111);
        run_op(mk_cw(op_load, 1), 32'h0000_1003, 32'h101, 32'h0, 4'b0110, 0, 0, 32'h8001_2300, 0,
               32'h0000_0123, 1, 32'h0000_0123, 32'h0, 4'b1111);
        run_op(mk_cw(op_load, 1), 32'h0000_1003, 32'h102, 32'h0, 4'b1100, 0, 0, 32'h8001_2300, 0,
               32'hFFFF_8001, 1, 32'hFFFF_8001, 32'h0, 4'b1111);
        run_op(mk_cw(op_load, 1), 32'h0000_5003, 32'h102, 32'h0, 4'b1100, 0, 0, 32'h8001_2300, 0,
               32'h0000_8001, 1, 32'h0000_8001, 32'h0, 4'b1111);
        run_op(mk_cw(op_load, 1), 32'h0000_2003, 32'h102, 32'h0, 4'b1111, 0, 0, 32'h5555_5555, 1,
               32'h0, 0, 32'h0, 32'h0, 4'b1111);
        run_op(mk_cw(op_store, 0), 32'h0000_1023, 32'h203, 32'h1234, 4'b1000, 0, 0, 32'h0, 1,
               32'h0, 0, 32'h203, 32'h0, 4'b0000);
        run_op(mk_cw(op_reg, 1), 32'h0000_2033, 32'h55, 32'h0, 4'b0000, 1, 0, 32'h0, 0,
               32'h0, 1, 32'h1, 32'h0, 4'b0000);
        run_op(mk_cw(op_imm, 1), 32'h0000_0013, 32'h1234, 32'h0, 4'b0000, 1, 0, 32'h0, 0,
               32'h0, 1, 32'h1234, 32'h0, 4'b0000);

        // Reset while a load is waiting in ACCESS; its response arrives after reset.
        @(negedge clk);
        ctrl_word_in = mk_cw(op_load, 1); instruction_in = 32'h0000_2003; alu_in = 32'h500;
        addr_offset_in = 2'd0; dmem_resp = 1'b0; #1;
        chk("acc_read_c0", {31'b0, dmem_read}, 32'd1);
        @(negedge clk); #1;
        chk("acc_read_c1", {31'b0, dmem_read}, 32'd1);
        chk("acc_stall_c1", {31'b0, MA_stall}, 32'd1);
        rst = 1'b1; ctrl_word_in = '0; instruction_in = 32'h0; alu_in = 32'h0; PC_in = 32'h0;
        rs2_in = 32'h0; mem_byte_enable_in = 4'h0; br_en_in = 1'b0; #1;
        chk("rst_acc_read", {31'b0, dmem_read}, 32'd0);
        chk("rst_acc_stall", {31'b0, MA_stall}, 32'd0);
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        e.instr = 0; e.pc = 0; e.alu = 0; e.mdr = 0; e.wb = 0; e.mis = 0; e.lrf = 0; e.br = 0;
        e.stall = 0; e.hs = exp_hs;
        exp_q.push_back(e);
        #1;
        chk("late_resp_read", {31'b0, dmem_read}, 32'd0);
        chk("late_resp_stall", {31'b0, MA_stall}, 32'd0);
        @(posedge clk); #2;
        chk("late_resp_ctrl", {19'b0, ctrl_word_out}, 32'd0);

        // Back-to-back hits: sw then lw, both answered in the issue cycle.
        run_op(mk_cw(op_store, 0), 32'h0000_2023, 32'h400, 32'hDEAD_BEEF, 4'b1111, 0, 0, 32'h0, 0,
               32'h0, 0, 32'h400, 32'hDEAD_BEEF, 4'b1111);
        run_op(mk_cw(op_load, 1), 32'h0000_2003, 32'h404, 32'h0, 4'b1111, 0, 0, 32'hCAFE_F00D, 0,
               32'hCAFE_F00D, 1, 32'hCAFE_F00D, 32'h0, 4'b1111);

        @(negedge clk);
        ctrl_word_in = '0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
